// File: rtl/cipu_pkg.sv
// Shared constants and FSM state types for the check-in/pickup host transmitter.
package cipu_pkg;

    localparam logic [7:0] CH_DOLLAR = 8'h24;
    localparam logic [7:0] CH_SEMI   = 8'h3B;
    localparam logic [7:0] IDLE_CH   = 8'h00;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARM,
        S_OPEN,
        S_RUN
    } sess_state_t;

    typedef enum logic [1:0] {
        P_IDLE,
        P_ARMED,
        P_SEND,
        P_DOLLAR
    } people_state_t;

    typedef enum logic [2:0] {
        T_IDLE,
        T_ARMED,
        T_SEND,
        T_WAIT,
        T_HOLD,
        T_END
    } thing_state_t;

endpackage

// File: rtl/cipu_char_buf.sv
// Append-only character store with a separate read pointer; the fill count is
// only cleared by reset, the read pointer restarts at every session.
module cipu_char_buf #(
    parameter int unsigned DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    input  logic       rd_clr,
    input  logic       rd_adv,
    output logic [7:0] rd_data,
    output logic       rd_last,
    output logic       rd_end,
    output logic       full,
    output logic       wr_drop
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned PW = $clog2(DEPTH + 1);

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] fill;
    logic [PW-1:0] rd_ptr;

    assign full    = (fill == PW'(DEPTH));
    assign wr_drop = wr_en && full;
    assign rd_end  = (rd_ptr == fill);
    assign rd_last = ((rd_ptr + PW'(1)) == fill);
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (wr_en && !full) begin
            mem[fill[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fill <= '0;
        end else if (wr_en && !full) begin
            fill <= fill + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || rd_clr) begin
            rd_ptr <= '0;
        end else if (rd_adv && !rd_end) begin
            rd_ptr <= rd_ptr + PW'(1);
        end
    end

endmodule

// File: rtl/cipu_host_tx.sv
// Host end of the check-in/pickup protocol: opens a session, streams passengers
// and baggage records, counts returned beats and reports completion.
module cipu_host_tx
    import cipu_pkg::*;
#(
    parameter int unsigned PEOPLE_DEPTH = 16,
    parameter int unsigned THING_DEPTH  = 64,
    parameter int unsigned MAX_REC      = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic       wr_sel,
    input  logic [7:0] wr_data,
    input  logic       num_en,
    input  logic [3:0] num_data,
    input  logic       start,
    output logic       ready_fifo,
    output logic       ready_lifo,
    output logic [7:0] people_thing_out,
    output logic [7:0] thing_out,
    output logic [3:0] thing_num,
    input  logic       valid_fifo,
    input  logic       valid_lifo,
    input  logic       valid_fifo2,
    input  logic       done_thing,
    input  logic       done_fifo,
    input  logic       done_lifo,
    input  logic       done_fifo2,
    output logic       busy,
    output logic       all_done,
    output logic       load_err,
    output logic [7:0] cnt_fifo,
    output logic [7:0] cnt_lifo,
    output logic [7:0] cnt_fifo2
);
    localparam int unsigned RW = $clog2(THING_DEPTH + 1);
    localparam int unsigned NW = $clog2(MAX_REC + 1);
    localparam int unsigned NA = (MAX_REC > 1) ? $clog2(MAX_REC) : 1;

    sess_state_t   sess, sess_nx;
    people_state_t p_st, p_nx;
    thing_state_t  t_st, t_nx;

    logic start_acc, launch, finish;
    logic seen_f, seen_f2;

    logic [7:0] p_data, t_data;
    logic       p_last, p_end, p_full, p_drop;
    logic       t_last, t_end, t_full, t_drop;

    logic [3:0]    nums [MAX_REC];
    logic [NW-1:0] num_cnt;
    logic          num_full;
    logic [RW-1:0] rec;
    logic [3:0]    cur_num;

    assign start_acc = start && !busy;
    assign launch    = (sess == S_OPEN);
    assign finish    = busy && seen_f && seen_f2;
    assign num_full  = (num_cnt == NW'(MAX_REC));

    cipu_char_buf #(.DEPTH(PEOPLE_DEPTH)) u_people_buf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en && !busy && !wr_sel),
        .wr_data (wr_data),
        .rd_clr  (start_acc),
        .rd_adv  (p_st == P_SEND),
        .rd_data (p_data),
        .rd_last (p_last),
        .rd_end  (p_end),
        .full    (p_full),
        .wr_drop (p_drop)
    );

    cipu_char_buf #(.DEPTH(THING_DEPTH)) u_thing_buf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en && !busy && wr_sel),
        .wr_data (wr_data),
        .rd_clr  (start_acc),
        .rd_adv  (t_st == T_SEND),
        .rd_data (t_data),
        .rd_last (t_last),
        .rd_end  (t_end),
        .full    (t_full),
        .wr_drop (t_drop)
    );

    always_ff @(posedge clk) begin
        if (num_en && !busy && !num_full) begin
            nums[num_cnt[NA-1:0]] <= num_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            num_cnt  <= '0;
            load_err <= 1'b0;
        end else begin
            if (num_en && !busy && !num_full) begin
                num_cnt <= num_cnt + NW'(1);
            end
            if (p_drop || t_drop || (num_en && !busy && num_full)) begin
                load_err <= 1'b1;
            end
        end
    end

    // Session sequencing: arm, one-cycle ready pulse, run until both done latches set.
    always_ff @(posedge clk) begin
        if (rst) sess <= S_IDLE;
        else     sess <= sess_nx;
    end

    always_comb begin
        sess_nx = sess;
        unique case (sess)
            S_IDLE: if (start) sess_nx = S_ARM;
            S_ARM:  sess_nx = S_OPEN;
            S_OPEN: sess_nx = S_RUN;
            S_RUN:  ;
        endcase
        if (finish) sess_nx = S_IDLE;
    end

    always_comb begin
        busy       = (sess != S_IDLE);
        ready_fifo = (sess == S_OPEN);
        ready_lifo = (sess == S_OPEN);
    end

    always_ff @(posedge clk) begin
        if (rst || start_acc) begin
            seen_f   <= 1'b0;
            seen_f2  <= 1'b0;
            all_done <= 1'b0;
            cnt_fifo <= '0;
            cnt_lifo <= '0;
            cnt_fifo2 <= '0;
        end else begin
            if (busy && done_fifo)  seen_f  <= 1'b1;
            if (busy && done_fifo2) seen_f2 <= 1'b1;
            if (finish)             all_done <= 1'b1;
            if (busy && valid_fifo  && cnt_fifo  != '1) cnt_fifo  <= cnt_fifo  + 8'd1;
            if (busy && valid_lifo  && cnt_lifo  != '1) cnt_lifo  <= cnt_lifo  + 8'd1;
            if (busy && valid_fifo2 && cnt_fifo2 != '1) cnt_fifo2 <= cnt_fifo2 + 8'd1;
        end
    end

    // People channel
    always_ff @(posedge clk) begin
        if (rst) p_st <= P_IDLE;
        else     p_st <= p_nx;
    end

    always_comb begin
        p_nx = p_st;
        unique case (p_st)
            P_IDLE:   ;
            P_ARMED:  if (launch) p_nx = p_end ? P_DOLLAR : P_SEND;
            P_SEND:   if (p_last) p_nx = P_DOLLAR;
            P_DOLLAR: if (done_lifo) p_nx = P_IDLE;
        endcase
        if (start_acc)              p_nx = P_ARMED;
        else if (!busy || finish)   p_nx = P_IDLE;
    end

    always_comb begin
        unique case (p_st)
            P_SEND:   people_thing_out = p_data;
            P_DOLLAR: people_thing_out = CH_DOLLAR;
            default:  people_thing_out = IDLE_CH;
        endcase
    end

    // Thing channel; T_HOLD shows the next record's first character one extra cycle
    // before T_SEND re-presents it and starts advancing.
    always_ff @(posedge clk) begin
        if (rst) t_st <= T_IDLE;
        else     t_st <= t_nx;
    end

    always_comb begin
        t_nx = t_st;
        unique case (t_st)
            T_ARMED: if (launch) t_nx = t_end ? T_END : T_SEND;
            T_SEND:  if (t_data == CH_SEMI || t_last) t_nx = T_WAIT;
            T_WAIT:  if (done_thing) t_nx = t_end ? T_END : T_HOLD;
            T_HOLD:  t_nx = T_SEND;
            default: ;
        endcase
        if (start_acc)              t_nx = T_ARMED;
        else if (!busy || finish)   t_nx = T_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst || start_acc) begin
            rec <= '0;
        end else if (t_st == T_WAIT && done_thing) begin
            rec <= rec + RW'(1);
        end
    end

    always_comb begin
        cur_num = 4'h0;
        if (32'(rec) < 32'(num_cnt)) cur_num = nums[rec[NA-1:0]];
    end

    always_comb begin
        thing_out = IDLE_CH;
        thing_num = 4'h0;
        unique case (t_st)
            T_SEND, T_HOLD: begin
                thing_out = t_data;
                thing_num = cur_num;
            end
            T_WAIT:  thing_num = cur_num;
            default: ;
        endcase
    end

endmodule

// File: doc/cipu_host_tx.md
Name: cipu_host_tx

Overview:
- Transmit/host end of the check-in/pickup character protocol.
- Software preloads a passenger string and baggage records, then pulses start.
- The block opens a session on ready_fifo/ready_lifo, streams passenger letters and '$' on the people channel, and streams digit/';' baggage records on the thing channel, pacing each record on done_thing.
- It counts returned valid beats and flags completion once done_fifo and done_fifo2 have both been seen.

Parameters:
PEOPLE_DEPTH, 16, passenger character buffer entries
THING_DEPTH, 64, baggage character buffer entries (digits plus ';' terminators)
MAX_REC, 16, max baggage records (one thing_num each)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
wr_en  in  1  write one character into the buffer chosen by wr_sel
wr_sel  in  1  0 = people buffer, 1 = thing buffer
wr_data  in  8  ASCII character to store
num_en  in  1  append one thing_num entry
num_data  in  4  thing_num for the next record
start  in  1  one-cycle start pulse
ready_fifo  out  1  session open, people side
ready_lifo  out  1  session open, thing side
people_thing_out  out  8  people channel character
thing_out  out  8  thing channel character
thing_num  out  4  take-count for the current record
valid_fifo  in  1  returned people beat
valid_lifo  in  1  returned LIFO baggage beat
valid_fifo2  in  1  returned FIFO2 baggage beat
done_thing  in  1  current record fully processed
done_fifo  in  1  people side finished
done_lifo  in  1  thing side finished
done_fifo2  in  1  FIFO2 side finished
busy  out  1  session in progress
all_done  out  1  completion flag, sticky until start or rst
load_err  out  1  sticky write-overflow flag
cnt_fifo, cnt_lifo, cnt_fifo2  out  8 each  returned beat counters

Behaviour:
Reset and load rules:
- rst clears buffer fill counts, read pointers, record index, counters and flags.
- Reset values: ready_* = 0, people_thing_out = thing_out = 8'h00, thing_num = 0, busy = 0.
- Reset mid-session aborts immediately with no trailing '$'.
- Writes are accepted only when !busy.
- A write to a full buffer is dropped and sets load_err.
- A thing buffer with no trailing ';' sends its partial record as-is. This is legal stimulus; the host does not check it.

Session start:
- start while busy is ignored.
- start while idle: busy = 1, all_done = 0, counters = 0, pointers = 0.
- Cycle S+1: ready_fifo = ready_lifo = 1 for exactly one cycle.
- Cycle S+2: both ready lines are low and first characters are presented on both channels. The consumer takes first data on the edge where it sees ready fall.

People channel FSM: P_SEND -> P_DOLLAR -> P_IDLE
- P_SEND: one buffered character per cycle.
- P_DOLLAR: hold '$' until done_lifo is sampled high, then 8'h00.
- Empty people buffer: '$' is sent at S+2.

Thing channel FSM: T_SEND -> T_WAIT -> T_HOLD -> T_SEND ... -> T_END
- T_SEND: one character per cycle. thing_num = num[rec] for the whole record.
- After ';' is driven: T_WAIT, thing_out = 8'h00 until done_thing is sampled high.
- On that edge, load the next record's first character and enter T_HOLD. That character is held for 2 cycles (covers the consumer's done-clear cycle), then T_SEND advances one per cycle.
- After the last record's done_thing: T_END, thing_out = 8'h00. This lets the held '$' close the thing side.
- Zero records: T_END from S+2.
- thing_out must never be 8'h00 while records remain and the state is not T_WAIT. Otherwise the consumer would terminate early.

Counters and completion:
- cnt_* increment by 1 on each cycle the matching valid_* is high while busy, saturating at 8'hFF.
- done_fifo and done_fifo2 are latched independently (any order, same cycle allowed).
- When both are latched: all_done = 1 and busy = 0 on the next edge.
- done_* inputs outside a session are ignored.
- num_en beyond MAX_REC sets load_err.
- Records without a num entry use thing_num = 0.

Decomposition:
- Package cipu_pkg: ASCII constants ('$' = 8'h24, ';' = 8'h3B, IDLE_CH = 8'h00) and the people/thing FSM state encodings.
- One natural sub-module: cipu_char_buf, a parameterised write-append / read-pointer character store with full flag. Instantiated twice, for people and thing buffers.

Test Plan:
- Load "ABC", records "12;"(num 1) and "345;"(num 2), start -> ready pulse at S+1; people A,B,C at S+2..S+4 then '$' held; thing 1,2,; at S+2..S+4 then 8'h00 until done_thing; after done_lifo/fifo/fifo2, all_done = 1 with cnt_fifo = 3, cnt_lifo = 3, cnt_fifo2 = 2 from a reference consumer.
- done_thing sampled at edge E -> next record first char '3' on thing_out for E..E+2 edges, '4' at E+2, thing_num = 2 throughout.
- Empty people buffer, zero records -> '$' at S+2, thing_out = 8'h00, all_done after done_fifo and done_fifo2 with counters 0.
- 17 people writes with PEOPLE_DEPTH = 16 -> load_err = 1, 16 characters stored; start while busy -> no second ready pulse.
- Assert rst during T_WAIT -> next cycle all outputs at reset values; new start runs a clean session from pointer 0 with empty buffers.
- done_fifo and done_fifo2 in the same cycle -> all_done asserted exactly one edge later; valid_lifo held for 300 cycles -> cnt_lifo saturates at 255.
